// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a start bit, then shifts
// one command byte out on device-generated clock falling edges and checks the ACK.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_INHIBIT     = 3'd1;
  localparam logic [2:0] S_START       = 3'd2;
  localparam logic [2:0] S_SEND        = 3'd3;
  localparam logic [2:0] S_ACK_WAIT    = 3'd4;
  localparam logic [2:0] S_ACK_RELEASE = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [1:0]       clk_sync_q, data_sync_q;
  logic [5:0]       hist_q, hist_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic clk_s, data_s, fall;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  // Three stable highs followed by three stable lows filters glitches on the slow bus clock.
  assign fall   = (hist_q == 6'b111000);

  // Ready drops during the done/error pulse so it rises strictly one cycle later.
  assign tx_ready    = (state_q == S_IDLE) && !done_q && !err_q;
  assign busy        = !tx_ready;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_error    = err_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    hist_d    = {hist_q[4:0], clk_s};

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid && tx_ready) begin
          shift_d   = {1'b1, ~^tx_data, tx_data};
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        inh_cnt_d = inh_cnt_q + INH_W'(1);
        if (inh_cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = S_START;
        end
      end

      S_START: begin
        // History reset hides the falling edge our own inhibit produced.
        clk_oe_d  = 1'b0;
        hist_d    = '0;
        to_cnt_d  = '0;
        bit_idx_d = '0;
        state_d   = S_SEND;
      end

      S_SEND, S_ACK_WAIT, S_ACK_RELEASE: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (to_cnt_q == TO_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_IDLE;
        end else begin
          case (state_q)
            S_SEND: begin
              if (fall) begin
                data_oe_d = ~shift_q[0];
                shift_d   = {1'b0, shift_q[9:1]};
                bit_idx_d = bit_idx_q + 4'd1;
                if (bit_idx_q == 4'd9) state_d = S_ACK_WAIT;
              end
            end
            S_ACK_WAIT: begin
              data_oe_d = 1'b0;
              if (fall) begin
                if (!data_s) begin
                  state_d = S_ACK_RELEASE;
                end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
                end
              end
            end
            default: begin
              data_oe_d = 1'b0;
              if (clk_s && data_s) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
              end
            end
          endcase
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      hist_q      <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      inh_cnt_q   <= inh_cnt_d;
      to_cnt_q    <= to_cnt_d;
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      hist_q      <= hist_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: an open-drain bus and PS/2 device model, with
// expected frames queued at request time and compared as the device clocks them in.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_error;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  wire        ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  wire        ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .tx_done(tx_done), .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  logic [9:0] exp_q[$];

  int n_inh = 0, n_st = 0, n_done = 0, n_err = 0, n_clash = 0;
  logic pulse_q = 1'b0;

  always @(negedge clk) begin
    if (ps2_clk_oe && !ps2_data_oe) n_inh++;
    if (ps2_clk_oe && ps2_data_oe) n_st++;
    if (tx_done) n_done++;
    if (tx_error) n_err++;
    if ((tx_done && tx_error) || ((tx_done || tx_error) && tx_ready)) n_clash++;
    if (pulse_q && !tx_ready && !reset) n_clash++;
    pulse_q = tx_done || tx_error;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction

  task automatic send(input logic [7:0] d, input bit push);
    tick();
    tx_data  = d;
    tx_valid = 1'b1;
    check("ready_at_req", tx_ready, 1);
    if (push) exp_q.push_back(frame_of(d));
    tick();
    tx_valid = 1'b0;
  endtask

  // Returns on the first sample where the host has released the clock after inhibiting.
  task automatic wait_release();
    int k = 0;
    while (ps2_clk_oe !== 1'b1 && k < 100) begin tick(); k++; end
    check("inhibit_seen", k < 100, 1);
    k = 0;
    while (ps2_clk_oe !== 1'b0 && k < INH + 50) begin tick(); k++; end
    check("clk_released", k < INH + 50, 1);
  endtask

  task automatic device(input bit ack, input int nedges);
    logic [9:0] got = '0;
    wait_release();
    check("start_bit", ps2_data_in, 0);
    for (int i = 0; i < nedges; i++) begin
      if (i == 10 && ack) dev_data = 1'b0;
      repeat (HALF) tick();
      dev_clk = 1'b0;
      repeat (HALF) tick();
      if (i < 10) got[i] = ps2_data_in;
      if (i == 10) check("ack_data_oe", ps2_data_oe, 0);
      dev_clk = 1'b1;
    end
    repeat (HALF) tick();
    dev_data = 1'b1;
    if (nedges == 11) begin
      if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
      else check("frame", got, exp_q.pop_front());
    end
  endtask

  task automatic wait_pulse(input int base);
    int k = 0;
    while ((n_done + n_err) == base && k < 300) begin tick(); k++; end
    check("pulse_seen", k < 300, 1);
    repeat (3) tick();
  endtask

  task automatic good_xfer(input logic [7:0] d);
    int inh0 = n_inh, st0 = n_st, d0 = n_done, e0 = n_err;
    send(d, 1'b1);
    device(1'b1, 11);
    wait_pulse(d0 + e0);
    check("inhibit_len", n_inh - inh0, INH);
    check("start_len", n_st - st0, 1);
    check("done_cnt", n_done - d0, 1);
    check("err_cnt", n_err - e0, 0);
    check("ready_after", tx_ready, 1);
  endtask

  initial begin
    int d0, e0, inh0, k;

    repeat (3) tick();
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_done", tx_done, 0);
    check("rst_error", tx_error, 0);
    reset = 1'b0;
    repeat (3) tick();

    good_xfer(8'hED);
    good_xfer(8'h00);
    good_xfer(8'h01);

    // Device never pulls data low on the 11th edge.
    d0 = n_done; e0 = n_err;
    send(8'h3C, 1'b1);
    device(1'b0, 11);
    wait_pulse(d0 + e0);
    check("nack_err", n_err - e0, 1);
    check("nack_done", n_done - d0, 0);
    check("nack_clk_oe", ps2_clk_oe, 0);
    check("nack_data_oe", ps2_data_oe, 0);
    check("nack_ready", tx_ready, 1);

    // Device never clocks: timeout counted from the first cycle after START.
    d0 = n_done; e0 = n_err;
    send(8'h55, 1'b0);
    wait_release();
    check("to_start_bit", ps2_data_oe, 1);
    k = 0;
    while (tx_error !== 1'b1 && k < TO + 500) begin tick(); k++; end
    check("to_cycles", k, TO);
    check("to_clk_oe", ps2_clk_oe, 0);
    check("to_data_oe", ps2_data_oe, 0);
    check("to_done", tx_done, 0);
    tick();
    check("to_ready", tx_ready, 1);
    check("to_err_cnt", n_err - e0, 1);

    // Reset while data bit 4 (a 0 for 0x0F) is being driven.
    d0 = n_done; e0 = n_err;
    send(8'h0F, 1'b0);
    device(1'b0, 5);
    check("mid_data_oe", ps2_data_oe, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_data_oe", ps2_data_oe, 0);
    check("rst_async_clk_oe", ps2_clk_oe, 0);
    check("rst_async_ready", tx_ready, 1);
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    check("rst_no_pulse", (n_done - d0) + (n_err - e0), 0);
    good_xfer(8'hFF);

    // A request arriving mid-transfer must be dropped.
    d0 = n_done; e0 = n_err;
    send(8'h3C, 1'b1);
    fork
      device(1'b1, 11);
      begin
        repeat (120) tick();
        check("busy_mid", tx_ready, 0);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
      end
    join
    wait_pulse(d0 + e0);
    check("ign_done", n_done - d0, 1);
    inh0 = n_inh;
    repeat (100) tick();
    check("ign_no_restart", n_inh - inh0, 0);
    check("sb_empty", exp_q.size(), 0);
    check("no_clash", n_clash, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
